cpu_mul_seq: RTL and testbench
==============================

Name: cpu_mul_seq

Overview:
- Multi-cycle 32x32 multiply sequencer for the Nios II A-stage multiply path.
- Produces the full 64-bit product and returns either the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS).
- Feeds one 16x16 unsigned partial product per cycle through a single registered hard multiplier, then accumulates and sign-corrects the result.
- Sits between the decode/operand stage (upstream) and the result writeback mux (downstream).

Parameters:
SHORT_MUL, 1, when 1 the MUL op skips the a_hi*b_hi product (latency 6 instead of 7); when 0 every op takes the same latency.
MUL_PIPE, 1, latency of the 16x16 multiplier sub-module in cycles; only the value 1 is supported.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a multiply; accepted when start=1 and in_ready=1.
op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed), 3=MULXSS.
src1  in  32  operand A.
src2  in  32  operand B.
kill  in  1  flush the in-flight operation (pipeline exception).
in_ready  out  1  block is idle and can accept start.
result  out  32  selected product word; valid only while result_valid=1.
result_valid  out  1  result available; held until result_ready is sampled high.
result_ready  in  1  downstream consumes the result.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: in_ready=1, result_valid=0, result=0, accumulator=0, state=IDLE. Reset mid-operation aborts it; no result is produced.
- Start: operands and op are latched on the accepting edge. start while in_ready=0 is ignored; there is no queueing.
- States:
  - IDLE → ISSUE on accept.
  - ISSUE runs 4 cycles with cnt 0..3, issuing pp0=a_lo*b_lo, pp1=a_hi*b_lo, pp2=a_lo*b_hi, pp3=a_hi*b_hi. With SHORT_MUL=1 and op=MUL, pp3 is skipped (3 cycles).
  - ISSUE → DRAIN (1 cycle) so the last product can return.
  - DRAIN → CORRECT (1 cycle).
  - CORRECT → DONE.
  - DONE → IDLE when result_ready=1.
- Accumulation: each product returns one cycle after issue.
  - Accumulator is 64-bit unsigned: acc += pp<<0 (pp0), pp<<16 (pp1, pp2), pp<<32 (pp3).
  - All adds wrap modulo 2^64.
- Sign correction (CORRECT state), applied to the high word modulo 2^32:
  - hi -= src2 if (op is MULXSU or MULXSS) and src1[31].
  - hi -= src1 if op is MULXSS and src2[31].
- Result select: result = acc[31:0] for MUL, acc[63:32] otherwise. result is registered and stable while result_valid=1.
- Latency: start accepted on edge T → result_valid=1 in the cycle after edge T+7 (T+6 for a short MUL).
- Back-to-back: in_ready rises in the cycle after result_ready is sampled high, so the minimum gap between accepts is latency+1 cycles.
- Kill:
  - In any non-IDLE state, kill returns the block to IDLE on the next edge with result_valid=0; a killed result is never presented.
  - Kill in the same cycle as start in IDLE: kill wins and the start is not accepted.
  - Kill during DONE drops the pending result.
- result_ready while result_valid=0 has no effect.

Decomposition:
- Shared package cpu_mul_pkg holds:
  - op encodings (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS);
  - state enum (IDLE, ISSUE, DRAIN, CORRECT, DONE);
  - the constant PP_SHIFT per cnt.
- One sub-module, cpu_mul_pp16: a 16x16 unsigned multiplier with one output register and synchronous reset, mapping to one dedicated multiplier block.
- The sequencer FSM, accumulator and correction logic stay in cpu_mul_seq.

Test Plan:
- MULXUU src1=0xFFFFFFFF src2=0xFFFFFFFF → result 0xFFFFFFFE; result_valid exactly 7 cycles after accept; MUL with the same operands → 0x00000001 (6 cycles with SHORT_MUL=1).
- MULXSS 0xFFFFFFFF*0xFFFFFFFF → 0x00000000; MULXSS 0x80000000*0x80000000 → 0x40000000; MULXSS 0x80000000*0x00000002 → 0xFFFFFFFF.
- MULXSU src1=0xFFFFFFFF src2=0xFFFFFFFF → 0xFFFFFFFF; MULXSU src1=0x00000002 src2=0x80000000 → 0x00000001.
- Hold result_ready=0 for 5 cycles after result_valid → result and result_valid stay stable and in_ready=0; a start pulsed during the hold is ignored; release → in_ready=1 next cycle.
- Assert kill in ISSUE cnt=2, then reset during DRAIN of a fresh op → no result_valid pulse either time; outputs match reset values; the next MUL 0x00010000*0x00010000 → 0x00000000 and MULXUU → 0x00000001.
- Assert start and kill together in IDLE → not accepted (in_ready stays 1, no result); then 1000 random op/operand pairs → match the 64-bit reference model.

Source files
------------

// File: rtl/cpu_mul_pkg.sv
// Shared encodings and constants for the sequential 32x32 multiplier.
package cpu_mul_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned PP_W   = 32;
  localparam int unsigned ACC_W  = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    CORRECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Accumulator shift for partial product issued at cnt 0..3 (index 0 is rightmost)
  localparam logic [3:0][5:0] PP_SHIFT = {6'd32, 6'd16, 6'd16, 6'd0};

endpackage

// File: rtl/cpu_mul_pp16.sv
// 16x16 unsigned multiplier with a single output register; maps onto one hard multiplier.
module cpu_mul_pp16
  import cpu_mul_pkg::*;
#(
  parameter int unsigned MUL_PIPE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [PP_W-1:0]   p
);

  always_ff @(posedge clk) begin
    if (reset) p <= '0;
    else       p <= PP_W'(a) * PP_W'(b);
  end

endmodule

// File: rtl/cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer: four 16x16 partial products, accumulate, sign-correct.
module cpu_mul_seq
  import cpu_mul_pkg::*;
#(
  parameter bit          SHORT_MUL = 1'b1,
  parameter int unsigned MUL_PIPE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            in_ready,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready
);

  state_t            state;
  op_t               op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [1:0]        cnt;
  logic [ACC_W-1:0]  acc;
  logic              pp_vld;
  logic [1:0]        pp_cnt;
  logic [PP_W-1:0]   pp;

  logic [1:0]        last_cnt_c;
  logic [HALF_W-1:0] mul_a_c;
  logic [HALF_W-1:0] mul_b_c;
  logic [XLEN-1:0]   hi_fix_c;
  logic [XLEN-1:0]   sel_c;

  // cnt[0] picks a_hi (pp1, pp3); cnt[1] picks b_hi (pp2, pp3)
  always_comb begin
    last_cnt_c = (SHORT_MUL && (op_q == OP_MUL)) ? 2'd2 : 2'd3;
    mul_a_c    = cnt[0] ? a_q[XLEN-1:HALF_W] : a_q[HALF_W-1:0];
    mul_b_c    = cnt[1] ? b_q[XLEN-1:HALF_W] : b_q[HALF_W-1:0];
  end

  // Convert the unsigned high word into the signed variants
  always_comb begin
    hi_fix_c = acc[ACC_W-1:XLEN];
    if (((op_q == OP_MULXSU) || (op_q == OP_MULXSS)) && a_q[XLEN-1]) hi_fix_c = hi_fix_c - b_q;
    if ((op_q == OP_MULXSS) && b_q[XLEN-1])                           hi_fix_c = hi_fix_c - a_q;
    sel_c = (op_q == OP_MUL) ? acc[XLEN-1:0] : acc[ACC_W-1:XLEN];
  end

  cpu_mul_pp16 #(.MUL_PIPE(MUL_PIPE)) u_pp16 (
    .clk   (clk),
    .reset (reset),
    .a     (mul_a_c),
    .b     (mul_b_c),
    .p     (pp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      result_valid <= 1'b0;
      result       <= '0;
      acc          <= '0;
      cnt          <= '0;
      op_q         <= OP_MUL;
      a_q          <= '0;
      b_q          <= '0;
      pp_vld       <= 1'b0;
      pp_cnt       <= '0;
    end else begin
      // Product issued last cycle returns now and is folded into the accumulator
      pp_vld <= (state == ISSUE) && !kill;
      pp_cnt <= cnt;
      if (pp_vld) acc <= acc + (ACC_W'(pp) << PP_SHIFT[pp_cnt]);

      case (state)
        IDLE: begin
          if (start && !kill) begin
            op_q     <= op_t'(op);
            a_q      <= src1;
            b_q      <= src2;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= 2'(cnt + 2'd1);
          if (cnt == last_cnt_c) state <= DRAIN;
        end
        DRAIN:   state <= CORRECT;
        CORRECT: begin
          acc[ACC_W-1:XLEN] <= hi_fix_c;
          state             <= DONE;
        end
        DONE: begin
          if (!result_valid) begin
            result_valid <= 1'b1;
            result       <= sel_c;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Pipeline flush drops whatever is in flight, including a pending result
      if (kill && (state != IDLE)) begin
        state        <= IDLE;
        in_ready     <= 1'b1;
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Directed and random self-checking bench for cpu_mul_seq (SHORT_MUL=1).
module tb_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        kill;
  logic        in_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_mul_seq #(.SHORT_MUL(1'b1), .MUL_PIPE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .src1         (src1),
    .src2         (src2),
    .kill         (kill),
    .in_ready     (in_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = ((o == 2'd2) || (o == 2'd3)) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'd3) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op from idle, wait (bounded) for result_valid, then consume it. lat=0 means timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    res = 32'hDEAD_BEEF;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = i; break; end
    end
    if (lat != 0) begin
      res = result;
      result_ready = 1'b1;
      @(posedge clk); #1 result_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", result); end
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int lat;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    n_tests++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulxuu_ff got=%h exp=fffffffe", r); end
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL mulxuu_latency got=%0d exp=7", lat); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_after_consume got=%b exp=1", in_ready); end
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    n_tests++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_ff got=%h exp=00000001", r); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL mul_short_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int lat;
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    n_tests++; if (r !== 32'h0000_0000) begin n_fail++; $display("FAIL mulxss_m1_m1 got=%h exp=00000000", r); end
    run_op(2'd3, 32'h8000_0000, 32'h8000_0000, r, lat);
    n_tests++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulxss_min_min got=%h exp=40000000", r); end
    run_op(2'd3, 32'h8000_0000, 32'h0000_0002, r, lat);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulxss_min_2 got=%h exp=ffffffff", r); end
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulxsu_m1_ff got=%h exp=ffffffff", r); end
    run_op(2'd2, 32'h0000_0002, 32'h8000_0000, r, lat);
    n_tests++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mulxsu_2_min got=%h exp=00000001", r); end
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL mulxsu_latency got=%0d exp=7", lat); end
  endtask

  task automatic test_backpressure();
    bit seen;
    bit bad;
    op = 2'd0; src1 = 32'h0000_1234; src2 = 32'h0000_0010; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL hold_valid_timeout got=0 exp=1"); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin op = 2'd1; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; start = 1'b1; end
      @(posedge clk); #1 start = 1'b0;
      if (result_valid !== 1'b1 || result !== 32'h0001_2340 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++; if (bad || result !== 32'h0001_2340) begin n_fail++; $display("FAIL hold_stable got=%h v=%b r=%b exp=00012340 v=1 r=0", result, result_valid, in_ready); end
    result_ready = 1'b1;
    @(posedge clk); #1 result_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || result_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got r=%b v=%b exp r=1 v=0", in_ready, result_valid); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    n_tests++; if (seen) begin n_fail++; $display("FAIL hold_start_ignored got=1 exp=0"); end
  endtask

  task automatic test_kill_reset();
    logic [31:0] r;
    int lat;
    bit seen;
    op = 2'd1; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    n_tests++; if (seen || in_ready !== 1'b1) begin n_fail++; $display("FAIL kill_issue got v=%b r=%b exp v=0 r=1", seen, in_ready); end
    op = 2'd3; src1 = 32'h8000_0001; src2 = 32'h7FFF_FFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    n_tests++; if (seen || in_ready !== 1'b1 || result !== 32'h0) begin n_fail++; $display("FAIL reset_drain got v=%b r=%b res=%h exp v=0 r=1 res=0", seen, in_ready, result); end
    run_op(2'd0, 32'h0001_0000, 32'h0001_0000, r, lat);
    n_tests++; if (r !== 32'h0000_0000 || lat == 0) begin n_fail++; $display("FAIL post_kill_mul got=%h lat=%0d exp=00000000", r, lat); end
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, r, lat);
    n_tests++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL post_kill_mulxuu got=%h exp=00000001", r); end
  endtask

  task automatic test_start_kill();
    bit seen;
    op = 2'd1; src1 = 32'h0000_0003; src2 = 32'h0000_0005; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_kill_accepted got=%b exp=1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    n_tests++; if (seen) begin n_fail++; $display("FAIL start_kill_result got=1 exp=0"); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic [1:0]  o;
    int lat;
    int errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom_range(3, 0));
      a = $urandom();
      b = $urandom();
      if (i % 7 == 0) a[31] = 1'b1;
      if (i % 5 == 0) b[31] = 1'b1;
      exp_r = ref_mul(o, a, b);
      run_op(o, a, b, r, lat);
      n_tests++;
      if (r !== exp_r || lat == 0) begin
        n_fail++;
        if (errs < 10) $display("FAIL random op=%0d a=%h b=%h got=%h exp=%h lat=%0d", o, a, b, r, exp_r, lat);
        errs++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; src1 = '0; src2 = '0; kill = 1'b0; result_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_kill_reset();
    test_start_kill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
